// File: rtl/multicycle_control_unit.sv
// Five-phase multi-cycle control FSM (IF/ID/EXE/MEM/WB) driving every datapath
// select and write enable, plus a retired-instruction counter for debug.
module multicycle_control_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic        InsMemRW,
  output logic        IRWre,
  output logic        ExtSel,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        DataMemRW,
  output logic        DBDataSrc,
  output logic        RegOut,
  output logic        RegWre,
  output logic        halted,
  output logic [15:0] retired
);

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [2:0]  state_q, state_d;
  logic [15:0] retired_q, retired_d;

  logic       is_alu, is_ls, is_beq, is_j, is_halt;
  logic [2:0] alu_op_dec;
  logic       src_a_dec, src_b_dec, ext_dec, rd_dst_dec;

  // Instruction decode: class plus the ALU-side controls shared by EXE and WB_AL
  always_comb begin
    is_alu     = 1'b0;
    is_ls      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_halt    = 1'b0;
    alu_op_dec = 3'b000;
    src_a_dec  = 1'b0;
    src_b_dec  = 1'b0;
    ext_dec    = 1'b0;
    rd_dst_dec = 1'b0;
    case (opcode)
      OP_ADD:  begin is_alu = 1'b1; rd_dst_dec = 1'b1; end
      OP_SUB:  begin is_alu = 1'b1; rd_dst_dec = 1'b1; alu_op_dec = 3'b001; end
      OP_ADDI: begin is_alu = 1'b1; src_b_dec = 1'b1; ext_dec = 1'b1; end
      OP_OR:   begin is_alu = 1'b1; rd_dst_dec = 1'b1; alu_op_dec = 3'b011; end
      OP_AND:  begin is_alu = 1'b1; rd_dst_dec = 1'b1; alu_op_dec = 3'b100; end
      OP_ORI:  begin is_alu = 1'b1; src_b_dec = 1'b1; alu_op_dec = 3'b011; end
      OP_SLL:  begin is_alu = 1'b1; rd_dst_dec = 1'b1; src_a_dec = 1'b1; alu_op_dec = 3'b010; end
      OP_SLT:  begin is_alu = 1'b1; rd_dst_dec = 1'b1; alu_op_dec = 3'b101; end
      OP_SW, OP_LW: begin is_ls = 1'b1; src_b_dec = 1'b1; ext_dec = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; ext_dec = 1'b1; alu_op_dec = 3'b001; end
      OP_J:    is_j = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_alu)       state_d = S_EXE_AL;
        else if (is_ls)   state_d = S_EXE_LS;
        else if (is_beq)  state_d = S_EXE_BR;
        else if (is_halt) state_d = S_ID;
        else              state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  // Anything not asserted for the current state stays 0; illegal opcodes retire as NOPs in ID
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    InsMemRW  = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    DataMemRW = 1'b0;
    DBDataSrc = 1'b0;
    RegOut    = 1'b0;
    RegWre    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      S_ID: begin
        if (is_halt) begin
          halted = 1'b1;
        end else if (is_j) begin
          PCWre = 1'b1;
          PCSrc = 2'b10;
        end else if (!is_alu && !is_ls && !is_beq) begin
          PCWre = 1'b1;
        end
      end
      S_EXE_AL, S_EXE_LS, S_EXE_BR, S_WB_AL: begin
        ALUOp   = alu_op_dec;
        ALUSrcA = src_a_dec;
        ALUSrcB = src_b_dec;
        ExtSel  = ext_dec;
        if (state_q == S_EXE_BR) begin
          PCWre = 1'b1;
          PCSrc = zero ? 2'b01 : 2'b00;
        end
        if (state_q == S_WB_AL) begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
          RegOut = rd_dst_dec;
        end
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          DataMemRW = 1'b1;
          PCWre     = 1'b1;
        end
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired_d = PCWre ? retired_q + 16'd1 : retired_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IF;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
